// File: rtl/tcb_lite_lib_arbiter_pkg.sv
// Shared constants and helpers for the two-manager TCB-lite arbiter.
package tcb_lite_lib_arbiter_pkg;

    // Deepest subordinate read delay the response pipeline supports.
    localparam int unsigned ARB_DLY_MAX = 4;

    // Index of the port owning the bus: the granted port, or `pri` when idle.
    function automatic logic arb_sel(input logic [1:0] gnt, input logic pri);
        if (gnt[1]) begin
            return 1'b1;
        end else if (gnt[0]) begin
            return 1'b0;
        end
        return pri;
    endfunction

    // The port that gets top priority after `port` has won a transfer.
    function automatic logic arb_other(input logic port);
        return ~port;
    endfunction

endpackage

// File: rtl/tcb_lite_lib_arbiter_rr2.sv
// Two-input round-robin grant with its priority register.
module tcb_lite_lib_arbiter_rr2
    import tcb_lite_lib_arbiter_pkg::*;
#(
    parameter logic RST_PRI = 1'b0
)(
    input  logic       clk,
    input  logic       rst,    // active-low, asynchronous
    input  logic [1:0] req,
    input  logic       xfer,
    output logic [1:0] gnt,
    output logic       pri
);

    logic pri_q;
    logic pri_d;

    // A lone requester always wins; a tie goes to the port named by pri.
    always_comb begin
        gnt    = 2'b00;
        gnt[0] = req[0] & (~req[1] | ~pri_q);
        gnt[1] = req[1] & (~req[0] |  pri_q);
    end

    // The winner of a completed transfer drops to lowest priority; stalls hold.
    always_comb begin
        pri_d = pri_q;
        if (xfer) begin
            pri_d = arb_other(arb_sel(gnt, pri_q));
        end
    end

    // Priority register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pri_q <= RST_PRI;
        end else begin
            pri_q <= pri_d;
        end
    end

    assign pri = pri_q;

endmodule

// File: rtl/tcb_lite_lib_arbiter.sv
// Two-manager to one-subordinate TCB-lite arbiter with delayed response routing.
module tcb_lite_lib_arbiter
    import tcb_lite_lib_arbiter_pkg::*;
#(
    parameter int unsigned ADR     = 32,
    parameter int unsigned DAT     = 32,
    parameter int unsigned DLY     = 1,
    parameter logic        RST_PRI = 1'b0
)(
    input  logic             clk,
    input  logic             rst,    // active-low, asynchronous
    // manager 0 (instruction fetch)
    input  logic             s0_vld,
    output logic             s0_rdy,
    input  logic             s0_wen,
    input  logic [ADR-1:0]   s0_adr,
    input  logic [DAT/8-1:0] s0_ben,
    input  logic [DAT-1:0]   s0_wdt,
    output logic [DAT-1:0]   s0_rdt,
    output logic             s0_err,
    // manager 1 (load/store)
    input  logic             s1_vld,
    output logic             s1_rdy,
    input  logic             s1_wen,
    input  logic [ADR-1:0]   s1_adr,
    input  logic [DAT/8-1:0] s1_ben,
    input  logic [DAT-1:0]   s1_wdt,
    output logic [DAT-1:0]   s1_rdt,
    output logic             s1_err,
    // subordinate
    output logic             m_vld,
    input  logic             m_rdy,
    output logic             m_wen,
    output logic [ADR-1:0]   m_adr,
    output logic [DAT/8-1:0] m_ben,
    output logic [DAT-1:0]   m_wdt,
    input  logic [DAT-1:0]   m_rdt,
    input  logic             m_err
);

    if (DLY > ARB_DLY_MAX) begin : g_dly_check
        $error("tcb_lite_lib_arbiter: DLY=%0d outside 0..%0d", DLY, ARB_DLY_MAX);
    end

    logic [1:0] req;
    logic [1:0] gnt;
    logic       pri;
    logic       sel;
    logic       xfer;
    logic       rsp_vld;
    logic       rsp_own;

    // Requests are masked during reset so nothing reaches the subordinate.
    assign req  = {s1_vld, s0_vld} & {2{rst}};
    assign sel  = arb_sel(gnt, pri);
    assign xfer = m_vld & m_rdy;

    tcb_lite_lib_arbiter_rr2 #(
        .RST_PRI (RST_PRI)
    ) u_rr2 (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .xfer (xfer),
        .gnt  (gnt),
        .pri  (pri)
    );

    // Request path: zero-latency mux of the owning port onto the subordinate.
    always_comb begin
        m_vld  = |req;
        m_wen  = sel ? s1_wen : s0_wen;
        m_adr  = sel ? s1_adr : s0_adr;
        m_ben  = sel ? s1_ben : s0_ben;
        m_wdt  = sel ? s1_wdt : s0_wdt;
        s0_rdy = gnt[0] & m_rdy;
        s1_rdy = gnt[1] & m_rdy;
    end

    if (DLY == 0) begin : g_rsp_comb
        // Subordinate answers in the same cycle: route by the live grant.
        assign rsp_vld = xfer;
        assign rsp_own = sel;
    end else begin : g_rsp_pipe
        logic [DLY-1:0] vld_q;
        logic [DLY-1:0] own_q;

        // Valid bits track in-flight transfers; reset discards them at once.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                vld_q <= '0;
            end else begin
                vld_q[0] <= xfer;
                for (int i = 1; i < DLY; i++) begin
                    vld_q[i] <= vld_q[i-1];
                end
            end
        end

        // Owner bits are only meaningful under a set valid bit, so no reset.
        always_ff @(posedge clk) begin
            own_q[0] <= sel;
            for (int i = 1; i < DLY; i++) begin
                own_q[i] <= own_q[i-1];
            end
        end

        assign rsp_vld = vld_q[DLY-1];
        assign rsp_own = own_q[DLY-1];
    end

    // Read data is broadcast; the error flag goes only to the transfer's owner.
    always_comb begin
        s0_rdt = m_rdt;
        s1_rdt = m_rdt;
        s0_err = m_err & rsp_vld & ~rsp_own;
        s1_err = m_err & rsp_vld &  rsp_own;
    end

endmodule

// File: tb/tb_tcb_lite_lib_arbiter.sv
// Bench: DLY=1 and DLY=3 arbiters driven in parallel, scoreboard on responses.
module tb_tcb_lite_lib_arbiter;

    localparam logic [31:0] ERR_ADR = 32'h8000_0100;

    typedef struct {
        int          due;
        logic        own;
        logic [31:0] rdt;
        logic        err;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        s0_vld, s0_wen, s1_vld, s1_wen, m_rdy;
    logic [31:0] s0_adr, s0_wdt, s1_adr, s1_wdt;
    logic [3:0]  s0_ben, s1_ben;

    logic        m_vld_b [2];
    logic        m_wen_b [2];
    logic [31:0] m_adr_b [2];
    logic [3:0]  m_ben_b [2];
    logic [31:0] m_wdt_b [2];
    logic [31:0] m_rdt_b [2];
    logic        m_err_b [2];
    logic        s0_rdy_b [2];
    logic        s1_rdy_b [2];
    logic [31:0] s0_rdt_b [2];
    logic [31:0] s1_rdt_b [2];
    logic        s0_err_b [2];
    logic        s1_err_b [2];

    logic [33:0] line [2][3];
    rsp_t        q [2][$];
    logic        pri_m;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return a ^ 32'h5A5A_1234;
    endfunction

    tcb_lite_lib_arbiter #(.ADR(32), .DAT(32), .DLY(1), .RST_PRI(1'b0)) dut1 (
        .clk(clk), .rst(rst),
        .s0_vld(s0_vld), .s0_rdy(s0_rdy_b[0]), .s0_wen(s0_wen), .s0_adr(s0_adr),
        .s0_ben(s0_ben), .s0_wdt(s0_wdt), .s0_rdt(s0_rdt_b[0]), .s0_err(s0_err_b[0]),
        .s1_vld(s1_vld), .s1_rdy(s1_rdy_b[0]), .s1_wen(s1_wen), .s1_adr(s1_adr),
        .s1_ben(s1_ben), .s1_wdt(s1_wdt), .s1_rdt(s1_rdt_b[0]), .s1_err(s1_err_b[0]),
        .m_vld(m_vld_b[0]), .m_rdy(m_rdy), .m_wen(m_wen_b[0]), .m_adr(m_adr_b[0]),
        .m_ben(m_ben_b[0]), .m_wdt(m_wdt_b[0]), .m_rdt(m_rdt_b[0]), .m_err(m_err_b[0])
    );

    tcb_lite_lib_arbiter #(.ADR(32), .DAT(32), .DLY(3), .RST_PRI(1'b0)) dut3 (
        .clk(clk), .rst(rst),
        .s0_vld(s0_vld), .s0_rdy(s0_rdy_b[1]), .s0_wen(s0_wen), .s0_adr(s0_adr),
        .s0_ben(s0_ben), .s0_wdt(s0_wdt), .s0_rdt(s0_rdt_b[1]), .s0_err(s0_err_b[1]),
        .s1_vld(s1_vld), .s1_rdy(s1_rdy_b[1]), .s1_wen(s1_wen), .s1_adr(s1_adr),
        .s1_ben(s1_ben), .s1_wdt(s1_wdt), .s1_rdt(s1_rdt_b[1]), .s1_err(s1_err_b[1]),
        .m_vld(m_vld_b[1]), .m_rdy(m_rdy), .m_wen(m_wen_b[1]), .m_adr(m_adr_b[1]),
        .m_ben(m_ben_b[1]), .m_wdt(m_wdt_b[1]), .m_rdt(m_rdt_b[1]), .m_err(m_err_b[1])
    );

    // Subordinate model: {valid, err, data} delay line per instance, not reset.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            line[k][2] <= line[k][1];
            line[k][1] <= line[k][0];
            line[k][0] <= {m_vld_b[k] && m_rdy, m_adr_b[k] == ERR_ADR, mem_f(m_adr_b[k])};
        end
    end
    assign m_rdt_b[0] = line[0][0][33] ? line[0][0][31:0] : 32'h0;
    assign m_err_b[0] = line[0][0][33] & line[0][0][32];
    assign m_rdt_b[1] = line[1][2][33] ? line[1][2][31:0] : 32'h0;
    assign m_err_b[1] = line[1][2][33] & line[1][2][32];

    // Scoreboard: reference grant model, pushes expected responses, pops on due cycle.
    always @(negedge clk) begin : mon
        logic       eg0, eg1, esel, xf;
        logic [1:0] eerr;
        rsp_t       e;
        if (!rst) begin
            pri_m = 1'b0;
            for (int k = 0; k < 2; k++) begin
                q[k].delete();
                total++;
                if ({m_vld_b[k], s0_rdy_b[k], s1_rdy_b[k], s0_err_b[k], s1_err_b[k]} !== 5'b0) begin
                    bad++;
                    $display("FAIL reset_outputs inst%0d: got %b want 00000", k,
                             {m_vld_b[k], s0_rdy_b[k], s1_rdy_b[k], s0_err_b[k], s1_err_b[k]});
                end
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                eerr = 2'b00;
                if (q[k].size() > 0 && q[k][0].due == cyc) begin
                    e = q[k].pop_front();
                    eerr = e.err ? (e.own ? 2'b10 : 2'b01) : 2'b00;
                    total++;
                    if (s0_rdt_b[k] !== e.rdt || s1_rdt_b[k] !== e.rdt) begin
                        bad++;
                        $display("FAIL rsp_data inst%0d cyc%0d: got %h/%h want %h", k, cyc,
                                 s0_rdt_b[k], s1_rdt_b[k], e.rdt);
                    end
                end
                total++;
                if ({s1_err_b[k], s0_err_b[k]} !== eerr) begin
                    bad++;
                    $display("FAIL rsp_err inst%0d cyc%0d: got %b want %b", k, cyc,
                             {s1_err_b[k], s0_err_b[k]}, eerr);
                end
            end
            eg0  = s0_vld && (!s1_vld || !pri_m);
            eg1  = s1_vld && (!s0_vld || pri_m);
            esel = eg1 ? 1'b1 : (eg0 ? 1'b0 : pri_m);
            xf   = (s0_vld || s1_vld) && m_rdy;
            for (int k = 0; k < 2; k++) begin
                total++;
                if ({m_vld_b[k], s0_rdy_b[k], s1_rdy_b[k]} !== {s0_vld | s1_vld, eg0 & m_rdy, eg1 & m_rdy}) begin
                    bad++;
                    $display("FAIL grant inst%0d cyc%0d: got vld/rdy0/rdy1=%b want %b", k, cyc,
                             {m_vld_b[k], s0_rdy_b[k], s1_rdy_b[k]}, {s0_vld | s1_vld, eg0 & m_rdy, eg1 & m_rdy});
                end
                if (s0_vld || s1_vld) begin
                    total++;
                    if ({m_wen_b[k], m_adr_b[k], m_ben_b[k], m_wdt_b[k]} !==
                        (esel ? {s1_wen, s1_adr, s1_ben, s1_wdt} : {s0_wen, s0_adr, s0_ben, s0_wdt})) begin
                        bad++;
                        $display("FAIL req_fields inst%0d cyc%0d: got adr %h want port%0d adr %h", k, cyc,
                                 m_adr_b[k], esel, esel ? s1_adr : s0_adr);
                    end
                end
                if (xf) begin
                    e.due = cyc + ((k == 1) ? 3 : 1);
                    e.own = esel;
                    e.rdt = mem_f(esel ? s1_adr : s0_adr);
                    e.err = (esel ? s1_adr : s0_adr) == ERR_ADR;
                    q[k].push_back(e);
                end
            end
            if (xf) pri_m = ~esel;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        s0_vld = 1'b0; s0_wen = 1'b0; s0_adr = 32'h0; s0_ben = 4'hF; s0_wdt = 32'h0;
        s1_vld = 1'b0; s1_wen = 1'b0; s1_adr = 32'h0; s1_ben = 4'hF; s1_wdt = 32'h0;
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        s0_vld = 1'b1; s1_vld = 1'b1; m_rdy = 1'b1;
        repeat (4) begin
            @(negedge clk);
            total++;
            if ({m_vld_b[0], s0_rdy_b[0], s1_rdy_b[0]} !== 3'b000) begin
                bad++;
                $display("FAIL test_reset: vld/rdy0/rdy1 got %b want 000", {m_vld_b[0], s0_rdy_b[0], s1_rdy_b[0]});
            end
        end
        step();
        rst = 1'b1;
        idle_inputs();
        step();
    endtask

    task automatic test_single_read();
        s0_vld = 1'b1; s0_adr = 32'h8000_0000; s0_wen = 1'b0; m_rdy = 1'b1;
        @(negedge clk);
        total++;
        if (m_adr_b[0] !== 32'h8000_0000 || s0_rdy_b[0] !== 1'b1 || s1_rdy_b[0] !== 1'b0) begin
            bad++;
            $display("FAIL single_read_req: adr %h rdy0 %b rdy1 %b want 80000000 1 0",
                     m_adr_b[0], s0_rdy_b[0], s1_rdy_b[0]);
        end
        step();
        idle_inputs();
        @(negedge clk);
        total++;
        if (s0_rdt_b[0] !== mem_f(32'h8000_0000) || s1_rdy_b[0] !== 1'b0) begin
            bad++;
            $display("FAIL single_read_rsp: rdt %h rdy1 %b want %h 0", s0_rdt_b[0], s1_rdy_b[0], mem_f(32'h8000_0000));
        end
        step();
    endtask

    task automatic test_alternate();
        int n0 = 0;
        int n1 = 0;
        pulse_reset();
        m_rdy = 1'b1;
        for (int i = 0; i < 100; i++) begin
            s0_vld = 1'b1; s0_adr = 32'h1000 + 32'(i * 4);
            s1_vld = 1'b1; s1_adr = 32'h2000 + 32'(i * 4);
            @(negedge clk);
            n0 += int'(s0_rdy_b[0]);
            n1 += int'(s1_rdy_b[0]);
            total++;
            if ({s0_rdy_b[0], s1_rdy_b[0]} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                bad++;
                $display("FAIL alternate cycle%0d: rdy0/rdy1 got %b want %b", i,
                         {s0_rdy_b[0], s1_rdy_b[0]}, (i % 2 == 0) ? 2'b10 : 2'b01);
            end
            step();
        end
        idle_inputs();
        total++;
        if (n0 != 50 || n1 != 50) begin
            bad++;
            $display("FAIL alternate_share: port0 %0d port1 %0d want 50 50", n0, n1);
        end
        step();
    endtask

    task automatic test_stall();
        pulse_reset();
        s0_vld = 1'b1; s0_adr = 32'h3000;
        s1_vld = 1'b1; s1_adr = 32'h4000;
        m_rdy  = 1'b0;
        repeat (5) begin
            @(negedge clk);
            total++;
            if ({m_vld_b[0], s0_rdy_b[0], s1_rdy_b[0]} !== 3'b100 || m_adr_b[0] !== 32'h3000) begin
                bad++;
                $display("FAIL stall_hold: vld/rdy0/rdy1 %b adr %h want 100 00003000",
                         {m_vld_b[0], s0_rdy_b[0], s1_rdy_b[0]}, m_adr_b[0]);
            end
            step();
        end
        m_rdy = 1'b1;
        @(negedge clk);
        total++;
        if (s0_rdy_b[0] !== 1'b1 || m_adr_b[0] !== 32'h3000) begin
            bad++;
            $display("FAIL stall_release: rdy0 %b adr %h want 1 00003000", s0_rdy_b[0], m_adr_b[0]);
        end
        step();
        @(negedge clk);
        total++;
        if (s1_rdy_b[0] !== 1'b1 || m_adr_b[0] !== 32'h4000) begin
            bad++;
            $display("FAIL stall_next: rdy1 %b adr %h want 1 00004000", s1_rdy_b[0], m_adr_b[0]);
        end
        step();
        idle_inputs();
        step();
    endtask

    task automatic test_write_err();
        s1_vld = 1'b1; s1_wen = 1'b1; s1_adr = ERR_ADR; s1_ben = 4'h3; s1_wdt = 32'hDEAD_BEEF;
        m_rdy  = 1'b1;
        @(negedge clk);
        total++;
        if (s1_rdy_b[0] !== 1'b1 || m_wen_b[0] !== 1'b1 || m_ben_b[0] !== 4'h3 || m_wdt_b[0] !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL write_req: rdy1 %b wen %b ben %h wdt %h want 1 1 3 deadbeef",
                     s1_rdy_b[0], m_wen_b[0], m_ben_b[0], m_wdt_b[0]);
        end
        step();
        idle_inputs();
        @(negedge clk);
        total++;
        if ({s1_err_b[0], s0_err_b[0]} !== 2'b10) begin
            bad++;
            $display("FAIL write_err: err1/err0 got %b want 10", {s1_err_b[0], s0_err_b[0]});
        end
        step();
    endtask

    task automatic test_dly3_stream();
        int exp_x = 0;
        int got_x = 0;
        for (int i = 0; i < 80; i++) begin
            s0_vld = 1'($urandom_range(0, 1));
            s1_vld = 1'($urandom_range(0, 1));
            m_rdy  = ($urandom_range(0, 3) != 0);
            s0_adr = ($urandom_range(0, 7) == 0) ? ERR_ADR : ($urandom & 32'hFFFF_FFFC);
            s1_adr = ($urandom_range(0, 7) == 0) ? ERR_ADR : ($urandom & 32'hFFFF_FFFC);
            @(negedge clk);
            if ((s0_vld || s1_vld) && m_rdy) exp_x++;
            if (s0_rdy_b[1] || s1_rdy_b[1]) got_x++;
            step();
        end
        idle_inputs();
        m_rdy = 1'b1;
        repeat (5) step();
        total++;
        if (got_x != exp_x) begin
            bad++;
            $display("FAIL dly3_xfer_count: got %0d want %0d", got_x, exp_x);
        end
    endtask

    task automatic test_reset_inflight();
        m_rdy  = 1'b1;
        s1_vld = 1'b1; s1_adr = ERR_ADR;
        step();
        idle_inputs();
        s0_vld = 1'b1; s0_adr = ERR_ADR;
        step();
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        step();
        rst = 1'b1;
        repeat (5) begin
            @(negedge clk);
            total++;
            if ({s0_err_b[0], s1_err_b[0], s0_err_b[1], s1_err_b[1]} !== 4'b0000) begin
                bad++;
                $display("FAIL reset_inflight_err: got %b want 0000",
                         {s0_err_b[0], s1_err_b[0], s0_err_b[1], s1_err_b[1]});
            end
            step();
        end
        s0_vld = 1'b1; s0_adr = 32'h5000;
        s1_vld = 1'b1; s1_adr = 32'h6000;
        @(negedge clk);
        total++;
        if ({s0_rdy_b[0], s1_rdy_b[0], s0_rdy_b[1], s1_rdy_b[1]} !== 4'b1010) begin
            bad++;
            $display("FAIL reset_first_grant: got %b want 1010",
                     {s0_rdy_b[0], s1_rdy_b[0], s0_rdy_b[1], s1_rdy_b[1]});
        end
        step();
        idle_inputs();
        repeat (6) step();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_alternate();
        test_stall();
        test_write_err();
        test_dly3_stream();
        test_reset_inflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
